jedro_1_mem_arbiter: RTL and testbench

- Shares one single-port byte-write RAM between the jedro_1 instruction-fetch port (read-only) and the load/store data port (read/write).
- Sits between jedro_1_top and the RAM, so a unified memory can replace the split ROM/RAM.
- Grants one request per cycle, tracks the owner of the single outstanding access, and routes the 1-cycle-latency response back to that owner.
- Data has fixed priority over fetch, with an anti-starvation counter for fetch.

---
 rtl/jedro_1_mem_arb_pkg.sv | 12 +
 rtl/jedro_1_mem_arb_starve_cnt.sv | 39 +++
 rtl/jedro_1_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_jedro_1_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_mem_arb_pkg.sv
// Shared types for the jedro_1 instruction/data memory arbiter.
package jedro_1_mem_arb_pkg;

  localparam int STARVE_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_INSTR = 2'd1,
    RESP_DATA  = 2'd2
  } resp_owner_e;

endpackage

// File: rtl/jedro_1_mem_arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; force_o makes fetch win next.
// Single cycle of state, force_o is a registered compare, no handshake of its own.
module jedro_1_mem_arb_starve_cnt
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic instr_req_i,
  input  logic instr_gnt_i,
  output logic force_o
);

  localparam logic [STARVE_CNT_WIDTH-1:0] MAX_CNT = STARVE_CNT_WIDTH'(MAX_STARVE);

  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!instr_req_i || instr_gnt_i) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != MAX_CNT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_o = (starve_cnt_q == MAX_CNT);

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one 1-cycle-latency byte-write RAM between fetch and load/store; data has priority.
// Combinational grants, rvalid one cycle later; JEDRO_1_MEM_ARB_PERF_EN adds perf counters.
module jedro_1_mem_arbiter
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef JEDRO_1_MEM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_conflict_o,
  output logic [31:0]             perf_forced_o
`endif
);

  logic        starve_force;
  resp_owner_e state_q;
  resp_owner_e state_d;

  jedro_1_mem_arb_starve_cnt #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .instr_req_i (instr_req_i),
    .instr_gnt_i (instr_gnt_o),
    .force_o     (starve_force)
  );

  // Fetch only beats a pending data request once it has been starved long enough.
  always_comb begin
    instr_gnt_o = !rst_i && instr_req_i && (!data_req_i || starve_force);
    data_gnt_o  = !rst_i && data_req_i && !instr_gnt_o;
  end

  always_comb begin
    mem_en_o    = instr_gnt_o || data_gnt_o;
    mem_addr_o  = data_gnt_o ? data_addr_i : instr_addr_i;
    mem_wdata_o = data_gnt_o ? data_wdata_i : '0;
    mem_we_o    = (data_gnt_o && data_we_i) ? data_be_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESP_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RESP_NONE;
    if (instr_gnt_o) begin
      state_d = RESP_INSTR;
    end else if (data_gnt_o) begin
      state_d = RESP_DATA;
    end
  end

  // Gating with rst_i drops a response that lands in a reset cycle.
  always_comb begin
    instr_rvalid_o = !rst_i && (state_q == RESP_INSTR);
    data_rvalid_o  = !rst_i && (state_q == RESP_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
  end

`ifdef JEDRO_1_MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_conflict_d;
  logic [31:0] perf_forced_q;
  logic [31:0] perf_forced_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_forced_d   = perf_forced_q;
    if (instr_req_i && data_req_i) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
    if (instr_gnt_o && data_req_i) begin
      perf_forced_d = perf_forced_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_conflict_q <= '0;
      perf_forced_q   <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_forced_q   <= perf_forced_d;
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_forced_o   = perf_forced_q;
`endif

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: directed vector table, contention sequence, random traffic vs model.
module tb_jedro_1_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [BW-1:0] data_be_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_en_o;
  logic [BW-1:0] mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
`ifdef JEDRO_1_MEM_ARB_PERF_EN
  logic [31:0]   perf_conflict_o;
  logic [31:0]   perf_forced_o;
`endif

  always #5 clk_i = ~clk_i;

  jedro_1_mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_STARVE (MAXS)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
`ifdef JEDRO_1_MEM_ARB_PERF_EN
    ,
    .perf_conflict_o (perf_conflict_o),
    .perf_forced_o   (perf_forced_o)
`endif
  );

  // RAM behind the arbiter: read-before-write, 1-cycle read latency.
  logic [DW-1:0] ram [64];
  logic [DW-1:0] ram_rdata;
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      ram_rdata <= ram[mem_addr_o[7:2]];
      for (int b = 0; b < BW; b++) begin
        if (mem_we_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end
  assign mem_rdata_i = ram_rdata;

  typedef struct packed {
    logic          rst;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          dreq;
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] daddr;
    logic [DW-1:0] wdata;
    logic          e_ig;
    logic          e_dg;
    logic          e_irv;
    logic          e_drv;
    logic [BW-1:0] e_we;
    logic          chk_rd;
    logic [DW-1:0] e_rd;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: requester-level view of the shared memory.
  int            m_denied = 0;
  int            m_owner  = 0;   // 0 none, 1 fetch, 2 data
  logic          m_owner_rd = 1'b0;
  logic [DW-1:0] m_owner_dat = '0;
  logic [DW-1:0] m_mem [64];
  logic          m_ig = 1'b0;
  int            m_conf = 0;
  int            m_forced = 0;
  bit            m_perf_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic ig, dg, forced;
    int   idx;
    ig = 1'b0;
    dg = 1'b0;
    forced = (m_denied >= MAXS);
    if (!rst_i) begin
      ig = instr_req_i && (!data_req_i || forced);
      dg = data_req_i && !ig;
    end
    chk("instr_gnt", 32'(instr_gnt_o), 32'(ig));
    chk("data_gnt", 32'(data_gnt_o), 32'(dg));
    chk("mem_en", 32'(mem_en_o), 32'(ig || dg));
    chk("mem_we", 32'(mem_we_o), (dg && data_we_i) ? 32'(data_be_i) : 32'd0);
    if (ig) chk("mem_addr_i", mem_addr_o, instr_addr_i);
    if (dg) chk("mem_addr_d", mem_addr_o, data_addr_i);
    if (dg && data_we_i) chk("mem_wdata", mem_wdata_o, data_wdata_i);
    chk("instr_rvalid", 32'(instr_rvalid_o), 32'(!rst_i && m_owner == 1));
    chk("data_rvalid", 32'(data_rvalid_o), 32'(!rst_i && m_owner == 2));
    if (!rst_i && m_owner == 1) chk("instr_rdata", instr_rdata_o, m_owner_dat);
    if (!rst_i && m_owner == 2 && m_owner_rd) chk("data_rdata", data_rdata_o, m_owner_dat);
`ifdef JEDRO_1_MEM_ARB_PERF_EN
    if (m_perf_known) begin
      chk("perf_conflict", perf_conflict_o, 32'(m_conf));
      chk("perf_forced", perf_forced_o, 32'(m_forced));
    end
`endif
    if (rst_i) begin
      m_denied = 0;
      m_owner = 0;
      m_conf = 0;
      m_forced = 0;
      m_perf_known = 1'b1;
    end else begin
      if (instr_req_i && data_req_i) m_conf++;
      if (ig && data_req_i) m_forced++;
      if (!instr_req_i || ig) m_denied = 0;
      else if (m_denied < MAXS) m_denied++;
      m_owner = ig ? 1 : (dg ? 2 : 0);
      if (ig) m_owner_dat = m_mem[instr_addr_i[7:2]];
      if (dg) begin
        idx = int'(data_addr_i[7:2]);
        m_owner_rd  = !data_we_i;
        m_owner_dat = m_mem[idx];
        if (data_we_i) begin
          for (int b = 0; b < BW; b++)
            if (data_be_i[b]) m_mem[idx][8*b +: 8] = data_wdata_i[8*b +: 8];
        end
      end
    end
    m_ig = ig;
  endtask

  task automatic step(input vec_t v, input bit use_exp);
    @(negedge clk_i);
    rst_i        = v.rst;
    instr_req_i  = v.ireq;
    instr_addr_i = v.iaddr;
    data_req_i   = v.dreq;
    data_we_i    = v.we;
    data_be_i    = v.be;
    data_addr_i  = v.daddr;
    data_wdata_i = v.wdata;
    #1;
    if (use_exp) begin
      chk("tbl_instr_gnt", 32'(instr_gnt_o), 32'(v.e_ig));
      chk("tbl_data_gnt", 32'(data_gnt_o), 32'(v.e_dg));
      chk("tbl_instr_rvalid", 32'(instr_rvalid_o), 32'(v.e_irv));
      chk("tbl_data_rvalid", 32'(data_rvalid_o), 32'(v.e_drv));
      chk("tbl_mem_we", 32'(mem_we_o), 32'(v.e_we));
      if (v.chk_rd) begin
        if (v.e_irv) chk("tbl_instr_rdata", instr_rdata_o, v.e_rd);
        else         chk("tbl_data_rdata", data_rdata_o, v.e_rd);
      end
    end
    model_check();
  endtask

  vec_t tbl [15];
  vec_t v;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]   = (i < 4) ? DW'(i) : '0;
      m_mem[i] = (i < 4) ? DW'(i) : '0;
    end
    ram[8]   = 32'hA5A5_0020;
    m_mem[8] = 32'hA5A5_0020;
    rst_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; data_req_i = 1'b0;
    data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;

    //          rst   ireq  iaddr   dreq  we    be     daddr   wdata          ig    dg    irv   drv   e_we   chk   rdata
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'h0,  1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'h0,  1'b1, 32'h1};
    tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 4'h0,  1'b1, 32'h2};
    tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 4'h3,  32'h10, 32'hDEADBEEF,  1'b0, 1'b1, 1'b0, 1'b0, 4'h3,  1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 4'hF,  32'h10, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 4'h0,  1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 4'h0,  1'b1, 32'h0000BEEF};
    tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 4'hF,  32'h20, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'h0,  1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 4'h0,  1'b1, 32'hA5A50020};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 4'h0,  1'b1, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 4'hF,  32'h20, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'h0,  1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 4'hF,  32'h20, 32'h12345678,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'h0,  32'h00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 4'h0,  1'b1, 32'h1};

    for (int i = 0; i < 15; i++) step(tbl[i], 1'b1);

    // Contention: both held for 10 cycles after a reset clears the perf counters.
    v = '0;
    v.rst = 1'b1;
    step(v, 1'b0);
    for (int k = 0; k < 10; k++) begin
      v = '0;
      v.ireq = 1'b1; v.iaddr = 32'h08;
      v.dreq = 1'b1; v.be = 4'hF; v.daddr = 32'h0C;
      step(v, 1'b0);
      chk("cont_instr_gnt", 32'(instr_gnt_o), 32'((k % 5) == 4));
      chk("cont_data_gnt", 32'(data_gnt_o), 32'((k % 5) != 4));
    end
    v = '0;
    step(v, 1'b0);
`ifdef JEDRO_1_MEM_ARB_PERF_EN
    chk("cont_perf_conflict", perf_conflict_o, 32'd10);
    chk("cont_perf_forced", perf_forced_o, 32'd2);
`endif

    // Random traffic with held requests.
    v = '0;
    for (int c = 0; c < 3000; c++) begin
      v.rst = ($urandom_range(0, 63) == 0);
      if (!v.ireq || m_ig) begin
        v.ireq  = ($urandom_range(0, 3) != 0);
        v.iaddr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!v.dreq || data_gnt_o) begin
        v.dreq  = ($urandom_range(0, 2) != 0);
        v.we    = $urandom_range(0, 1) == 1;
        v.be    = 4'($urandom_range(0, 15));
        v.daddr = 32'($urandom_range(0, 63)) << 2;
        v.wdata = $urandom;
      end
      step(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
